// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmit line among NUM_REQ byte producers.
// Sequences an external baud tick generator (one tick per bit period) for exactly one frame.
module uart_tx_sched #(
  parameter int NUM_REQ   = 2,
  parameter int STOP_BITS = 1,
  parameter int ID_W      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   baud_en,
  input  logic                   baud_tick,
  output logic                   txd,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic            stop_cnt_q;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] grant_q;
  logic            txd_q;
  logic            baud_en_q;
  logic            busy_q;

  logic [7:0]      req_bytes [NUM_REQ];
  logic [ID_W:0]   cand;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            handshake;
  logic            tick_ok;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[8*gi +: 8];
  end

  // Search starts one past the last winner and wraps; the first valid requester wins.
  always_comb begin
    cand    = '0;
    win_id  = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!win_vld && req_valid[cand[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && win_vld) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign handshake = rst_n && (state_q == IDLE) && win_vld;
  assign tick_ok   = baud_tick & baud_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      last_q     <= ID_W'(NUM_REQ - 1);
      grant_q    <= '0;
      txd_q      <= 1'b1;
      baud_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            shift_q   <= req_bytes[win_id];
            grant_q   <= win_id;
            last_q    <= win_id;
            txd_q     <= 1'b0;
            baud_en_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick_ok) begin
            bit_cnt_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (tick_ok) begin
            if (bit_cnt_q == 3'd7) begin
              txd_q      <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick_ok) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              baud_en_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd      = txd_q;
  assign baud_en  = baud_en_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmit line among NUM_REQ byte producers, e.g. the FFT result streamer and the debug/status reporter. It sequences an external baud tick generator: it asserts that generator's enable for exactly one frame and consumes its tick. The tick generator is instantiated with Oversampling=1, so one tick equals one bit period. Frame format is 8N1, with a configurable stop-bit count.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
STOP_BITS, 1, stop bits per frame (1 or 2)
ID_W, 1, width of grant_id; must equal max(1, clog2(NUM_REQ))

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  output  NUM_REQ  one-hot accept strobe; transfer occurs when valid&ready
baud_en  output  1  enable to the baud tick generator
baud_tick  input  1  one-cycle pulse per bit period from the generator
txd  output  1  serial line, idle high
busy  output  1  frame in progress
grant_id  output  ID_W  index of the requester owning the current or last frame

Behaviour:
- Reset (async assert, sync release): state=IDLE, txd=1, baud_en=0, busy=0, req_ready=0, grant_id=0, last-grant pointer=NUM_REQ-1 (requester 0 wins first).
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - req_ready is combinational. It is one-hot on the first i with req_valid[i]=1, searching from (last+1) mod NUM_REQ upward with wrap.
  - req_ready is all-zero if no valid is set, and all-zero in every state other than IDLE.
  - On handshake (cycle H):
    - latch the byte into shift_reg
    - grant_id and last are set to the winner
    - next state START
  - Handshake occurs only in the same cycle as valid; requesters must hold data while valid.
- START (entered H+1):
  - txd=0, baud_en=1, busy=1.
  - The generator reloads its phase while disabled, so the first tick arrives about one bit period later.
  - On baud_tick: go to DATA, bit_cnt=0, txd=shift_reg[0].
- DATA:
  - txd = current bit, LSB first.
  - On baud_tick: if bit_cnt=7, go to STOP with txd=1 and stop_cnt=0; otherwise shift right and bit_cnt+1.
- STOP:
  - txd=1.
  - On baud_tick: if stop_cnt=STOP_BITS-1, go to IDLE; otherwise stop_cnt+1.
- Outputs on return to IDLE: baud_en=0 and busy=0 are registered and take effect in the cycle after the final stop tick.
  - Arbitration resumes in that first IDLE cycle.
  - Minimum inter-frame gap on txd (high) = 1 clock beyond the stop bits.
- Output registration: txd, baud_en, busy and grant_id are registered. txd changes only in the cycle after a tick, or at H+1 for the start bit.
- baud_tick handling:
  - baud_tick in IDLE, including the handshake cycle, is ignored.
  - baud_tick is honoured only while baud_en=1.
- Changes on req_valid or req_data after the handshake have no effect on the frame in flight.
- Frame length: exactly 1 + 8 + STOP_BITS ticks from the first cycle of START to IDLE.
- Reset mid-frame:
  - txd returns to 1 and baud_en to 0 immediately.
  - The pointer returns to NUM_REQ-1.
  - No partial frame resumes.
- grant_id holds its value in IDLE until the next handshake.

Test Plan:
- Single byte:
  - Stimulus: req_valid[0]=1 with data 0xA5; tick every 16 clocks while baud_en=1.
  - Response: one req_ready[0] pulse; txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 clocks; baud_en high for exactly 10 tick periods, then low; busy mirrors baud_en; grant_id=0.
- Round robin:
  - Stimulus: both requesters valid continuously, data 0x11 and 0x22.
  - Response: grants alternate 0,1,0,1; txd frames carry 0x11,0x22,0x11,0x22; the gap between frames is 1 clock of txd=1.
- STOP_BITS=2:
  - Stimulus: byte 0x00.
  - Response: start bit plus eight 0 bits, then 2 tick periods of txd=1; the frame is 11 ticks.
- Ignored ticks:
  - Stimulus: pulse baud_tick in IDLE and in the handshake cycle.
  - Response: state stays IDLE or START respectively; txd does not advance; no spurious frame.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during DATA bit 3, then release; requester 1 is valid.
  - Response: txd=1 and baud_en=0 immediately; after release, requester 0 has priority if valid, otherwise requester 1 is granted; the new frame starts cleanly.
- Data hold:
  - Stimulus: change req_data[0] and drop req_valid[0] one cycle after the handshake.
  - Response: the transmitted byte equals the handshake-cycle value.
